// File: rtl/core_fetch_unit.sv
// Purpose : RV32 instruction fetch; owns the PC, issues word fetches, buffers {instr, pc} in a 2-entry FIFO.
// Latency : fetch issued one cycle after IDLE; instruction visible one cycle after its rvalid edge.
// Backpres: no new fetch while the FIFO holds 2 entries or a fetch is outstanding; redirect flushes.
module core_fetch_unit #(
   parameter int                        MEM_ADDR_WIDTH = 10,
   parameter int                        DATA_WIDTH     = 32,
   parameter logic [MEM_ADDR_WIDTH-1:0] RESET_PC       = '0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   output logic                      imem_req_o,
   output logic [MEM_ADDR_WIDTH-1:0] imem_addr_o,
   input  logic                      imem_gnt_i,
   input  logic                      imem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]     imem_rdata_i,
   output logic                      instr_valid_o,
   output logic [DATA_WIDTH-1:0]     instr_o,
   output logic [MEM_ADDR_WIDTH-1:0] instr_pc_o,
   input  logic                      instr_ready_i,
   input  logic                      redirect_i,
   input  logic [MEM_ADDR_WIDTH-1:0] redirect_pc_i
);

   localparam int AW = MEM_ADDR_WIDTH;

   // Word alignment: low two address bits are always forced to zero.
   localparam logic [AW-1:0] ALIGN_MASK    = {{(AW-2){1'b1}}, 2'b00};
   localparam logic [AW-1:0] RESET_PC_ALGN = RESET_PC & ALIGN_MASK;
   localparam logic [AW-1:0] PC_STEP       = AW'(4);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_WAIT  = 2'd2
   } state_e;

   state_e              state_q;
   logic [AW-1:0]       pc_q;
   logic [AW-1:0]       req_pc_q;
   logic                discard_q;

   logic [1:0]          count_q;
   logic [1:0]          count_d;
   logic                wr_ptr_q;
   logic                rd_ptr_q;
   logic [DATA_WIDTH-1:0] fifo_instr_q [2];
   logic [AW-1:0]       fifo_pc_q    [2];

   logic                fetch_gnt;
   logic                resp_vld;
   logic                push;
   logic                pop;
   logic [AW-1:0]       redirect_tgt;

   assign fetch_gnt    = (state_q == S_FETCH) && imem_gnt_i;
   assign resp_vld     = (state_q == S_WAIT) && imem_rvalid_i;
   // A redirect kills any push/pop on the same edge; stale or flagged responses never enter the FIFO.
   assign push         = resp_vld && !discard_q && !redirect_i;
   assign pop          = (count_q != 2'd0) && instr_ready_i && !redirect_i;
   assign redirect_tgt = redirect_pc_i & ALIGN_MASK;

   // Next FIFO occupancy; flush wins over everything.
   always_comb begin
      count_d = count_q;
      if (redirect_i) begin
         count_d = 2'd0;
      end else begin
         case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   // Fetch FSM: PC, request PC of the outstanding fetch, and stale-response discard flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC_ALGN;
         req_pc_q  <= '0;
         discard_q <= 1'b0;
      end else if (redirect_i) begin
         pc_q <= redirect_tgt;
         case (state_q)
            S_WAIT: begin
               if (imem_rvalid_i) begin
                  // Response lands on the redirect edge: drop it and fetch the target now.
                  state_q   <= S_FETCH;
                  discard_q <= 1'b0;
               end else begin
                  // Outstanding response belongs to the old path; swallow it when it arrives.
                  state_q   <= S_WAIT;
                  discard_q <= 1'b1;
               end
            end
            S_FETCH: begin
               if (imem_gnt_i) begin
                  // The old-path fetch was accepted this edge; its response must be dropped.
                  state_q   <= S_WAIT;
                  discard_q <= 1'b1;
               end else begin
                  state_q <= S_FETCH;
               end
            end
            default: begin
               state_q <= S_FETCH;
            end
         endcase
      end else begin
         case (state_q)
            S_IDLE: begin
               if (count_q <= 2'd1) begin
                  state_q <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (imem_gnt_i) begin
                  req_pc_q <= pc_q;
                  pc_q     <= pc_q + PC_STEP;
                  state_q  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_rvalid_i) begin
                  discard_q <= 1'b0;
                  // Only issue again if the FIFO can absorb the next response.
                  state_q   <= (count_d <= 2'd1) ? S_FETCH : S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Two-entry instruction FIFO with 1-bit wrap pointers; flush just resets the pointers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q         <= 2'd0;
         wr_ptr_q        <= 1'b0;
         rd_ptr_q        <= 1'b0;
         fifo_instr_q[0] <= '0;
         fifo_instr_q[1] <= '0;
         fifo_pc_q[0]    <= '0;
         fifo_pc_q[1]    <= '0;
      end else begin
         count_q <= count_d;
         if (redirect_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
         end else begin
            if (push) begin
               fifo_instr_q[wr_ptr_q] <= imem_rdata_i;
               fifo_pc_q[wr_ptr_q]    <= req_pc_q;
               wr_ptr_q               <= ~wr_ptr_q;
            end
            if (pop) begin
               rd_ptr_q <= ~rd_ptr_q;
            end
         end
      end
   end

   // All outputs come straight from registers; no path from ready/redirect to the request side.
   assign imem_req_o    = (state_q == S_FETCH);
   assign imem_addr_o   = pc_q;
   assign instr_valid_o = (count_q != 2'd0);
   assign instr_o       = fifo_instr_q[rd_ptr_q];
   assign instr_pc_o    = fifo_pc_q[rd_ptr_q];

   // The issue rule keeps occupancy within two entries.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !pop && (count_q == 2'd2)));
   a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
      count_q != 2'd3);

endmodule

// File: doc/core_fetch_unit.md
# core_fetch_unit

Instruction fetch stage of the RV32 core: owns the program counter, issues word fetches to instruction memory over a req/gnt/rvalid handshake and buffers returned instructions with their PC in a 2-entry FIFO for decode. Sits directly upstream of decode/execution; the PC delivered with each instruction becomes the execution unit's `old_pc_i`. It accepts absolute redirect targets (branches, jumps) computed downstream and flushes in-flight work.

## Interface
- `MEM_ADDR_WIDTH`, 10, byte-address width of instruction memory and PC
- `DATA_WIDTH`, 32, instruction word width
- `RESET_PC`, 0, PC loaded at reset (low 2 bits ignored)

- `clk`  in  1  core clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `imem_req_o`  out  1  fetch request
- `imem_addr_o`  out  MEM_ADDR_WIDTH  fetch byte address, word aligned
- `imem_gnt_i`  in  1  request accepted this cycle
- `imem_rvalid_i`  in  1  read data valid
- `imem_rdata_i`  in  DATA_WIDTH  fetched instruction
- `instr_valid_o`  out  1  FIFO head valid
- `instr_o`  out  DATA_WIDTH  head instruction
- `instr_pc_o`  out  MEM_ADDR_WIDTH  head instruction PC
- `instr_ready_i`  in  1  decode consumes head
- `redirect_i`  in  1  single-cycle redirect strobe
- `redirect_pc_i`  in  MEM_ADDR_WIDTH  absolute redirect target

## Operation
- Registers: `pc`, FSM state, FIFO (2 entries × {instr, pc}, `count` 0..2), `discard` flag.
- Reset (async, `rst_n`=0): `pc`=RESET_PC with bits[1:0]=0, state IDLE, `count`=0, `discard`=0, FIFO storage 0. Outputs: `imem_req_o`=0, `imem_addr_o`=RESET_PC&~3, `instr_valid_o`=0, `instr_o`=0, `instr_pc_o`=0.
- `imem_addr_o` = `pc`; `imem_req_o` = (state==FETCH). At most one fetch outstanding.
- IDLE: go FETCH when `count`≤1.
- FETCH: hold req. On `imem_gnt_i`: latch `req_pc`=`pc`, `pc`←`pc`+4 (modulo 2^MEM_ADDR_WIDTH, 0x3FC wraps to 0x000), go WAIT.
- WAIT: on `imem_rvalid_i`: if `discard`=0 push {rdata, `req_pc`}; else drop and clear `discard`. Next state FETCH if post-update `count`≤1, else IDLE.
- Pop when `instr_valid_o`&&`instr_ready_i`. Push and pop in the same cycle: `count` unchanged, order preserved. Issue rule (count≤1 with none outstanding) guarantees no overflow; push into full FIFO is unreachable.
- `instr_valid_o` = (`count`!=0); head fields come from the read pointer.
- Redirect (`redirect_i`=1) takes priority over everything else that edge:
  - FIFO flushed (`count`←0), concurrent push/pop ignored.
  - `pc`←`redirect_pc_i` with bits[1:0] forced 0.
  - WAIT without `imem_rvalid_i` this cycle, or FETCH with `imem_gnt_i` this cycle: go WAIT with `discard`=1 (stale response dropped).
  - WAIT with `imem_rvalid_i` this cycle: response dropped, go FETCH, `discard`=0.
  - FETCH without gnt, or IDLE: go FETCH.
- Redirect while `discard`=1 already set: `discard` stays 1, new target applies.

## Timing
- First `imem_req_o` rises on the 2nd rising edge after `rst_n` release (edge 1: IDLE→FETCH).
- `imem_addr_o` stable while `imem_req_o`=1 and `imem_gnt_i`=0, except changed on the edge after a redirect.
- `imem_rvalid_i` arrives ≥1 cycle after gnt; same-cycle gnt+rvalid is not supported.
- Push on rvalid edge → `instr_valid_o`=1 the following cycle.
- Zero-wait memory (gnt with req, rvalid next cycle): one instruction per 2 cycles.
- Redirect at edge N → `imem_addr_o`=target and req high after edge N (immediately, or after the discarded response returns).
- No combinational path from `instr_ready_i` or `redirect_i` to `imem_req_o`/`imem_addr_o`.

## Test plan
- Reset, RESET_PC=0x100, zero-wait memory, ready=1 → fetch addresses 0x100, 0x104, 0x108…; instr_pc_o tracks each word; req first high 2 cycles after reset release.
- ready=0 throughout → after 2 pushes (0x100, 0x104), req stays low; raising ready drains 0x100 then 0x104, fetch resumes at 0x108.
- Redirect to 0x040 while in WAIT for 0x108 → rvalid data for 0x108 dropped, FIFO empty, next fetch 0x040, next delivered PC 0x040.
- Redirect to 0x203 in the same cycle as gnt for 0x10C → response dropped, next fetch 0x200.
- PC reaches 0x3FC (10-bit) → next fetch 0x000, instr_pc_o 0x3FC then 0x000.
- `rst_n` asserted while WAIT with 2 entries full → valid=0, req=0 asynchronously; after release, restart at RESET_PC; late rvalid from the old request ignored.
